// File: rtl/net2axis_rr_arbiter_if.sv
// rtl/net2axis_rr_arbiter_if.sv - stream bundle between N replay sources, the arbiter and one sink
// master: arbiter view (drives merged stream and per-source ready); slave: environment view
interface net2axis_rr_arbiter_if #(
   parameter int N = 2,
   parameter int W = 32
);
   logic [N-1:0]       S_AXIS_TVALID;
   logic [N*W-1:0]     S_AXIS_TDATA;
   logic [N*W/8-1:0]   S_AXIS_TKEEP;
   logic [N-1:0]       S_AXIS_TLAST;
   logic [N-1:0]       S_AXIS_TREADY;
   logic               M_AXIS_TVALID;
   logic [W-1:0]       M_AXIS_TDATA;
   logic [W/8-1:0]     M_AXIS_TKEEP;
   logic               M_AXIS_TLAST;
   logic               M_AXIS_TREADY;

   modport master (
      input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, M_AXIS_TREADY,
      output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST
   );

   modport slave (
      output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, M_AXIS_TREADY,
      input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST
   );
endinterface

// File: rtl/net2axis_rr_arbiter.sv
// rtl/net2axis_rr_arbiter.sv - packet-level round-robin arbiter merging N streams into one sink
// Grant is taken in IDLE and held until the granted source's TLAST beat transfers.
module net2axis_rr_arbiter #(
   parameter int C_NUM_SOURCES = 2,
   parameter int C_TDATA_WIDTH = 32
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   net2axis_rr_arbiter_if.master             axis,
   output logic [$clog2(C_NUM_SOURCES)-1:0]  GRANT,
   output logic                              BUSY,
   output logic [15:0]                       PKT_COUNT
);
   localparam int N  = C_NUM_SOURCES;
   localparam int W  = C_TDATA_WIDTH;
   localparam int KW = W / 8;
   localparam int GW = $clog2(N);

   typedef enum logic {IDLE, XFER} state_t;

   state_t         state_q, state_d;
   logic [GW-1:0]  grant_q, grant_d;
   logic [GW-1:0]  ptr_q, ptr_d;
   logic [15:0]    pkt_count_q, pkt_count_d;

   logic           found;
   logic [GW-1:0]  pick;
   logic [GW:0]    scan;
   logic           last_beat;

   // Scan ptr, ptr+1, ... modulo N; the extra bit of scan absorbs the wrap.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      scan  = '0;
      for (int k = 0; k < N; k++) begin
         scan = {1'b0, ptr_q} + (GW+1)'(k);
         if (scan >= (GW+1)'(N)) begin
            scan = scan - (GW+1)'(N);
         end
         if (!found && axis.S_AXIS_TVALID[scan[GW-1:0]]) begin
            found = 1'b1;
            pick  = scan[GW-1:0];
         end
      end
   end

   always_comb begin
      axis.M_AXIS_TVALID = 1'b0;
      axis.M_AXIS_TDATA  = '0;
      axis.M_AXIS_TKEEP  = '0;
      axis.M_AXIS_TLAST  = 1'b0;
      axis.S_AXIS_TREADY = '0;
      if (state_q == XFER) begin
         axis.M_AXIS_TVALID         = axis.S_AXIS_TVALID[grant_q];
         axis.M_AXIS_TDATA          = axis.S_AXIS_TDATA[int'(grant_q)*W +: W];
         axis.M_AXIS_TKEEP          = axis.S_AXIS_TKEEP[int'(grant_q)*KW +: KW];
         axis.M_AXIS_TLAST          = axis.S_AXIS_TLAST[grant_q];
         axis.S_AXIS_TREADY[grant_q] = axis.M_AXIS_TREADY;
      end
   end

   assign last_beat = (state_q == XFER) && axis.S_AXIS_TVALID[grant_q]
                      && axis.M_AXIS_TREADY && axis.S_AXIS_TLAST[grant_q];

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      pkt_count_d = pkt_count_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               state_d = XFER;
            end
         end
         XFER: begin
            if (last_beat) begin
               state_d     = IDLE;
               ptr_d       = (grant_q == GW'(N-1)) ? '0 : grant_q + GW'(1);
               pkt_count_d = pkt_count_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         ptr_q       <= '0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign GRANT     = grant_q;
   assign BUSY      = (state_q == XFER);
   assign PKT_COUNT = pkt_count_q;
endmodule

// File: tb/tb_net2axis_rr_arbiter.sv
// tb/tb_net2axis_rr_arbiter.sv - directed vector bench for net2axis_rr_arbiter
module tb_net2axis_rr_arbiter;
   logic        clk;
   logic        rst_n;
   logic        grant;
   logic        busy;
   logic [15:0] pkt_count;
   int          checks;
   int          errors;

   net2axis_rr_arbiter_if #(.N(2), .W(32)) axis ();

   net2axis_rr_arbiter #(.C_NUM_SOURCES(2), .C_TDATA_WIDTH(32)) dut (
      .ACLK      (clk),
      .ARESETN   (rst_n),
      .axis      (axis),
      .GRANT     (grant),
      .BUSY      (busy),
      .PKT_COUNT (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst_n;
      logic [1:0]  vld;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  lst;
      logic        rdy;
      logic        e_vld;
      logic [31:0] e_data;
      logic [3:0]  e_keep;
      logic        e_last;
      logic [1:0]  e_trdy;
      logic        e_grant;
      logic        e_busy;
      logic [15:0] e_cnt;
   } vec_t;

   localparam int NV = 25;
   vec_t tbl [NV];

   function automatic vec_t mk(logic r, logic [1:0] v, logic [31:0] a, logic [31:0] b,
                               logic [1:0] l, logic y, logic ev, logic [31:0] ed,
                               logic [3:0] ek, logic el, logic [1:0] et, logic eg,
                               logic eb, logic [15:0] ec);
      vec_t t;
      t = {r, v, a, b, l, y, ev, ed, ek, el, et, eg, eb, ec};
      return t;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic [1:0] v, logic [31:0] a, logic [31:0] b, logic [1:0] l, logic y);
      axis.S_AXIS_TVALID = v;
      axis.S_AXIS_TDATA  = {b, a};
      axis.S_AXIS_TKEEP  = {4'h3, 4'hF};
      axis.S_AXIS_TLAST  = l;
      axis.M_AXIS_TREADY = y;
   endtask

   task automatic step(logic [1:0] v, logic [31:0] a, logic [31:0] b, logic [1:0] l);
      @(negedge clk);
      drive(v, a, b, l, 1'b1);
      #1;
   endtask

   task automatic chk_out(string tag, logic ev, logic [31:0] ed, logic el,
                          logic [1:0] et, logic eg, logic eb);
      chk({tag, " m_tvalid"}, 32'(axis.M_AXIS_TVALID), 32'(ev));
      chk({tag, " m_tdata"},  axis.M_AXIS_TDATA, ed);
      chk({tag, " m_tlast"},  32'(axis.M_AXIS_TLAST), 32'(el));
      chk({tag, " s_tready"}, 32'(axis.S_AXIS_TREADY), 32'(et));
      chk({tag, " grant"},    32'(grant), 32'(eg));
      chk({tag, " busy"},     32'(busy), 32'(eb));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      // rst vld d0 d1 lst rdy | vld data keep last trdy grant busy cnt
      tbl[0]  = mk(0, 2'b00, 0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 0, 0, 0);
      tbl[1]  = mk(1, 2'b01, 32'hA1, 0, 2'b00, 1,  0, 0, 0, 0, 2'b00, 0, 0, 0);
      tbl[2]  = mk(1, 2'b01, 32'hA1, 0, 2'b00, 1,  1, 32'hA1, 4'hF, 0, 2'b01, 0, 1, 0);
      tbl[3]  = mk(1, 2'b01, 32'hA2, 0, 2'b00, 1,  1, 32'hA2, 4'hF, 0, 2'b01, 0, 1, 0);
      tbl[4]  = mk(1, 2'b01, 32'hA3, 0, 2'b01, 1,  1, 32'hA3, 4'hF, 1, 2'b01, 0, 1, 0);
      tbl[5]  = mk(1, 2'b00, 0, 0, 2'b00, 1,  0, 0, 0, 0, 2'b00, 0, 0, 1);
      tbl[6]  = mk(0, 2'b00, 0, 0, 2'b00, 1,  0, 0, 0, 0, 2'b00, 0, 0, 0);
      tbl[7]  = mk(1, 2'b11, 32'hB0, 32'hC0, 2'b11, 1,  0, 0, 0, 0, 2'b00, 0, 0, 0);
      tbl[8]  = mk(1, 2'b11, 32'hB0, 32'hC0, 2'b11, 1,  1, 32'hB0, 4'hF, 1, 2'b01, 0, 1, 0);
      tbl[9]  = mk(1, 2'b11, 32'hB1, 32'hC1, 2'b11, 1,  0, 0, 0, 0, 2'b00, 0, 0, 1);
      tbl[10] = mk(1, 2'b11, 32'hB1, 32'hC1, 2'b11, 1,  1, 32'hC1, 4'h3, 1, 2'b10, 1, 1, 1);
      tbl[11] = mk(1, 2'b11, 32'hB2, 32'hC2, 2'b11, 1,  0, 0, 0, 0, 2'b00, 1, 0, 2);
      tbl[12] = mk(1, 2'b11, 32'hB2, 32'hC2, 2'b11, 1,  1, 32'hB2, 4'hF, 1, 2'b01, 0, 1, 2);
      tbl[13] = mk(1, 2'b11, 32'hB3, 32'hC3, 2'b11, 1,  0, 0, 0, 0, 2'b00, 0, 0, 3);
      tbl[14] = mk(1, 2'b11, 32'hB3, 32'hC3, 2'b11, 1,  1, 32'hC3, 4'h3, 1, 2'b10, 1, 1, 3);
      tbl[15] = mk(1, 2'b00, 0, 0, 2'b00, 1,  0, 0, 0, 0, 2'b00, 1, 0, 4);
      tbl[16] = mk(1, 2'b10, 0, 32'hD0, 2'b00, 1,  0, 0, 0, 0, 2'b00, 1, 0, 4);
      tbl[17] = mk(1, 2'b11, 32'hE0, 32'hD0, 2'b01, 1,  1, 32'hD0, 4'h3, 0, 2'b10, 1, 1, 4);
      tbl[18] = mk(1, 2'b11, 32'hE0, 32'hD1, 2'b01, 0,  1, 32'hD1, 4'h3, 0, 2'b00, 1, 1, 4);
      tbl[19] = mk(1, 2'b11, 32'hE0, 32'hD1, 2'b01, 1,  1, 32'hD1, 4'h3, 0, 2'b10, 1, 1, 4);
      tbl[20] = mk(1, 2'b11, 32'hE0, 32'hD2, 2'b11, 0,  1, 32'hD2, 4'h3, 1, 2'b00, 1, 1, 4);
      tbl[21] = mk(1, 2'b11, 32'hE0, 32'hD2, 2'b11, 1,  1, 32'hD2, 4'h3, 1, 2'b10, 1, 1, 4);
      tbl[22] = mk(1, 2'b01, 32'hE0, 32'hD2, 2'b01, 1,  0, 0, 0, 0, 2'b00, 1, 0, 5);
      tbl[23] = mk(1, 2'b01, 32'hE0, 32'hD2, 2'b01, 1,  1, 32'hE0, 4'hF, 1, 2'b01, 0, 1, 5);
      tbl[24] = mk(1, 2'b00, 0, 0, 2'b00, 1,  0, 0, 0, 0, 2'b00, 0, 0, 6);

      rst_n = 1'b0;
      drive(2'b00, 0, 0, 2'b00, 1'b0);
      repeat (2) @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         string tag;
         @(negedge clk);
         rst_n = tbl[i].rst_n;
         drive(tbl[i].vld, tbl[i].d0, tbl[i].d1, tbl[i].lst, tbl[i].rdy);
         #1;
         tag = $sformatf("vec%0d", i);
         chk_out(tag, tbl[i].e_vld, tbl[i].e_data, tbl[i].e_last, tbl[i].e_trdy,
                 tbl[i].e_grant, tbl[i].e_busy);
         chk({tag, " m_tkeep"}, 32'(axis.M_AXIS_TKEEP), 32'(tbl[i].e_keep));
         chk({tag, " pkt_count"}, 32'(pkt_count), 32'(tbl[i].e_cnt));
      end

      // src0 stalls mid-packet while src1 waits
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      drive(2'b11, 32'hF0, 32'h60, 2'b10, 1'b1);
      step(2'b11, 32'hF0, 32'h60, 2'b10);
      chk_out("stall first", 1, 32'hF0, 0, 2'b01, 0, 1);
      for (int c = 0; c < 5; c++) begin
         step(2'b10, 32'hF1, 32'h60, 2'b10);
         chk_out($sformatf("stall gap%0d", c), 0, 32'hF1, 0, 2'b01, 0, 1);
      end
      step(2'b11, 32'hF1, 32'h60, 2'b11);
      chk_out("stall last", 1, 32'hF1, 1, 2'b01, 0, 1);
      step(2'b10, 0, 32'h60, 2'b10);
      chk_out("stall bubble", 0, 0, 0, 2'b00, 0, 0);
      step(2'b10, 0, 32'h60, 2'b10);
      chk_out("stall src1", 1, 32'h60, 1, 2'b10, 1, 1);
      chk("stall pkt_count", 32'(pkt_count), 32'd1);

      // async reset mid-packet, then restart from source 0
      step(2'b00, 0, 0, 2'b00);
      step(2'b01, 32'h90, 0, 2'b01);
      step(2'b01, 32'h90, 0, 2'b01);
      chk_out("rst pkt0", 1, 32'h90, 1, 2'b01, 0, 1);
      step(2'b01, 32'h91, 0, 2'b00);
      step(2'b01, 32'h91, 0, 2'b00);
      chk_out("rst mid", 1, 32'h91, 0, 2'b01, 0, 1);
      chk("rst pre count", 32'(pkt_count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk_out("rst async", 0, 0, 0, 2'b00, 0, 0);
      chk("rst async count", 32'(pkt_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b11, 32'h92, 32'h70, 2'b11, 1'b1);
      step(2'b11, 32'h92, 32'h70, 2'b11);
      chk_out("rst restart", 1, 32'h92, 1, 2'b01, 0, 1);

      // PKT_COUNT wrap
      step(2'b00, 0, 0, 2'b00);
      chk("wrap pre", 32'(pkt_count), 32'd1);
      force dut.pkt_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.pkt_count_q;
      #1;
      chk("wrap preload", 32'(pkt_count), 32'hFFFF);
      step(2'b10, 0, 32'hAB, 2'b10);
      step(2'b10, 0, 32'hAB, 2'b10);
      chk_out("wrap beat", 1, 32'hAB, 1, 2'b10, 1, 1);
      step(2'b00, 0, 0, 2'b00);
      chk("wrap count", 32'(pkt_count), 32'h0000);
      chk("wrap busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
